// File: rtl/rr_packed_logb_unpacker.sv
// Replay-side logb unpacker: re-expands a gap-free packed record onto fixed per-channel slots.
// Optional build macro RR_UNPACK_LEN_CHECK_EN adds a sticky in_len vs. bitmap-derived length check.
module rr_packed_logb_unpacker #(
  parameter int unsigned LOGB_CHANNEL_CNT      = 4,
  parameter int unsigned RR_CHANNEL_WIDTH_BITS = 16,
  parameter bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    {16'd8, 16'd32, 16'd16, 16'd8},
  // Must equal the sum of CHANNEL_WIDTHS.
  parameter int unsigned FULL_WIDTH            = 64,
  parameter int unsigned OFFSET_WIDTH          = $clog2(FULL_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
  input  logic [FULL_WIDTH-1:0]       in_data,
  input  logic [OFFSET_WIDTH-1:0]     in_len,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LOGB_CHANNEL_CNT-1:0] out_logb_valid,
  output logic [FULL_WIDTH-1:0]       out_data,
  output logic [31:0]                 rec_cnt,
  output logic                        len_err
);

  localparam int unsigned N  = LOGB_CHANNEL_CNT;
  localparam int unsigned OW = OFFSET_WIDTH;

  // Fixed slot position of channel idx in the unpacked record.
  function automatic int unsigned get_offset(input int unsigned idx);
    int unsigned s;
    s = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (j < idx) s += 32'(CHANNEL_WIDTHS[j]);
    end
    return s;
  endfunction

  logic                  s1_full;
  logic                  s2_full;
  logic                  s1_adv_c;
  logic                  s2_adv_c;
  logic                  accept_c;
  logic                  s1_load_c;
  logic [N-1:0][OW-1:0]  off_c;
  logic [OW-1:0]         exp_len_c;
  logic [N-1:0][OW-1:0]  s1_off;
  logic [N-1:0]          s1_valid;
  logic [FULL_WIDTH-1:0] s1_data;
  logic [FULL_WIDTH-1:0] unpacked_c;

  assign s2_adv_c  = !s2_full || out_ready;
  assign s1_adv_c  = !s1_full || s2_adv_c;
  assign in_ready  = s1_adv_c;
  assign out_valid = s2_full;
  assign accept_c  = in_valid && s1_adv_c;
  assign s1_load_c = accept_c && (|in_logb_valid);

  // Prefix sum of present-channel widths gives each channel's packed offset.
  always_comb begin
    logic [OW-1:0] acc;
    acc   = '0;
    off_c = '0;
    for (int i = 0; i < N; i++) begin
      off_c[i] = acc;
      if (in_logb_valid[i]) acc = acc + OW'(CHANNEL_WIDTHS[i]);
    end
    exp_len_c = acc;
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    localparam int unsigned W   = 32'(CHANNEL_WIDTHS[i]);
    localparam int unsigned OFF = get_offset(i);
    assign unpacked_c[OFF +: W] = s1_valid[i] ? W'(s1_data >> s1_off[i]) : W'(0);
  end

  // Pipeline occupancy and emitted-record counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_full <= 1'b0;
      s2_full <= 1'b0;
      rec_cnt <= '0;
    end else begin
      if (s1_adv_c) s1_full <= s1_load_c;
      if (s2_adv_c) s2_full <= s1_full;
      if (s2_full && out_ready) rec_cnt <= rec_cnt + 32'd1;
    end
  end

  // Data path registers; meaningless while the matching full flag is clear.
  always_ff @(posedge clk) begin
    if (s1_load_c) begin
      s1_data  <= in_data;
      s1_valid <= in_logb_valid;
      s1_off   <= off_c;
    end
    if (s1_full && s2_adv_c) begin
      out_data       <= unpacked_c;
      out_logb_valid <= s1_valid;
    end
  end

`ifdef RR_UNPACK_LEN_CHECK_EN
  logic len_mismatch_c;

  // Empty bitmaps have exp_len 0, so they are covered by the same compare.
  assign len_mismatch_c = accept_c && (in_len != exp_len_c);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_err <= 1'b0;
    end else if (len_mismatch_c) begin
      len_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn && len_mismatch_c)
      $error("rr_packed_logb_unpacker: in_len %0d != expected %0d", in_len, exp_len_c);
  end
`endif
`else
  logic unused_len;

  assign unused_len = ^{in_len, exp_len_c};
  assign len_err    = 1'b0;
`endif

endmodule
